multiport_register_file: RTL
============================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter DATA_W, default 32, width of every register and data port.
REQ-002 Parameter ADDR_W, default 5; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Parameter NUM_WR, default 2, number of write ports (1..2).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 clk_enable  input  1  global enable; when low, no write, busy set or busy clear takes effect.
REQ-008 rd_addr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  NUM_RD*DATA_W  read data, packed the same way as rd_addr.
REQ-010 rd_busy  output  NUM_RD  high when the register addressed by the port has a pending write.
REQ-011 wr_en / wr_addr / wr_data  input  NUM_WR / NUM_WR*ADDR_W / NUM_WR*DATA_W  write ports.
REQ-012 mark_en, mark_addr  input  1, ADDR_W  flags a register as pending a write (load issue).
REQ-013 register_v0  output  DATA_W  continuous copy of register 2.

Function
REQ-014 Reads are combinational: rd_data[i] equals the stored value of rd_addr[i].
REQ-015 Register 0 reads as 0 at all times; writes to it are discarded; it is never busy.
REQ-016 A write stores wr_data at the rising edge when wr_en, clk_enable and reset are all high.
REQ-017 When two write ports target the same nonzero address in one cycle, the higher-indexed port wins.
REQ-018 Busy bits: mark_en sets busy[mark_addr] at the edge; any enabled write to an address clears its busy bit at the same edge.
REQ-019 If mark and write target the same address in one cycle, set wins: busy stays 1 and the data is still written.
REQ-020 rd_busy[i] = busy[rd_addr[i]]; it is combinational and never masked by bypass.
REQ-021 Out-of-range parameter values (NUM_RD or NUM_WR outside limits) are rejected at elaboration.

Reset
REQ-022 reset low clears all registers and busy bits immediately, without waiting for a clock edge.
REQ-023 While reset is low, rd_data, rd_busy and register_v0 read 0 and all writes and marks are ignored.
REQ-024 Reset asserted in the middle of a mark/write sequence discards the pending state; no write lands after deassertion.

Configuration
REQ-025 With REGFILE_BYPASS_EN defined, a read whose address matches an enabled same-cycle write (nonzero address) returns wr_data, applying the priority of REQ-017.
REQ-026 Without REGFILE_BYPASS_EN, reads return only the stored value; new data is visible from the cycle after the write.

Structure
REQ-027 Package regfile_pkg holds default DATA_W/ADDR_W, the REG_ZERO and REG_V0 index constants, and the port-limit constants.
REQ-028 Busy tracking is a sub-module, regfile_scoreboard (DEPTH busy bits with set/clear ports); the storage array and read muxing stay in the top module.

Verification
REQ-029 Reset low mid-test, then high -> all reads and register_v0 are 0; all rd_busy are 0.
REQ-030 Write 0xDEADBEEF to r2 on port 0 -> register_v0 is 0xDEADBEEF next cycle; write 0x1234 to r0 -> r0 still reads 0.
REQ-031 Ports 0 and 1 both write r5 (0x11 and 0x22) in one cycle -> r5 reads 0x22.
REQ-032 With the macro defined, write r7=0xA5 and read r7 in the same cycle -> rd_data is 0xA5 that cycle; without the macro -> old value that cycle, 0xA5 the next.
REQ-033 mark r9, then wait 3 cycles, then write r9=0x77 -> rd_busy high for 4 cycles, low after the write edge; mark and write r9 in one cycle -> busy stays 1 and r9 is 0x77.
REQ-034 clk_enable low during a write and a mark to r3 -> r3 and busy[3] are unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the multiport register file slice.
//   DEFAULT_*      default geometry and port counts
//   REG_ZERO       hard-wired zero register index
//   REG_V0         register mirrored on register_v0
//   MIN/MAX_*      legal port-count limits, checked at elaboration
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_NUM_RD = 2;
  localparam int DEFAULT_NUM_WR = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;

  localparam int MIN_RD_PORTS = 1;
  localparam int MAX_RD_PORTS = 4;
  localparam int MIN_WR_PORTS = 1;
  localparam int MAX_WR_PORTS = 2;

  function automatic bit in_range(int n, int lo, int hi);
    return (n >= lo) && (n <= hi);
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// multiport_register_file_if: bus bundle between a register-file user and
// the register file.
//   clk_enable              global enable for writes, marks and busy clears
//   rd_addr / rd_data       packed read ports, port i at [i*W +: W]
//   rd_busy                 per-read-port pending-write flag
//   wr_en/wr_addr/wr_data   packed write ports
//   mark_en / mark_addr     flag a register as pending a write
//   register_v0             continuous copy of register 2
// Modports: master (user side), slave (register file side).
import regfile_pkg::*;

interface multiport_register_file_if #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = DEFAULT_NUM_RD,
  parameter int NUM_WR = DEFAULT_NUM_WR
);

  logic                       clk_enable;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*ADDR_W-1:0]   wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;
  logic                       mark_en;
  logic [ADDR_W-1:0]          mark_addr;
  logic [DATA_W-1:0]          register_v0;

  modport master (
    output clk_enable, rd_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
    input  rd_data, rd_busy, register_v0
  );

  modport slave (
    input  clk_enable, rd_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
    output rd_data, rd_busy, register_v0
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register.
//   clk, reset     clock, asynchronous active-low reset
//   en_i           global enable; nothing changes while low
//   set_en_i/set_addr_i  mark a register as pending a write
//   clr_en_i/clr_addr_i  per write port, clear the busy bit of the target
//   busy_o         all busy bits, bit 0 always 0
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_WR = DEFAULT_NUM_WR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_i,
  input  logic                      set_en_i,
  input  logic [ADDR_W-1:0]         set_addr_i,
  input  logic [NUM_WR-1:0]         clr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]  clr_addr_i,
  output logic [(2**ADDR_W)-1:0]    busy_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clears are applied before the set so a same-cycle mark and write to one
  // register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (en_i) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (clr_en_i[w]) begin
          busy_d[clr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
        end
      end
      if (set_en_i) begin
        busy_d[set_addr_i] = 1'b1;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: 2**ADDR_W x DATA_W register file with NUM_RD
// combinational read ports, NUM_WR write ports and per-register busy bits.
//   clk     sole clock, rising edge
//   reset   asynchronous active-low reset; clears storage and busy bits and
//           forces all outputs to 0 while low
//   bus     multiport_register_file_if.slave (reads, writes, marks,
//           clk_enable, register_v0)
// Register 0 reads 0 and is never written or busy. On same-address writes
// the higher-indexed port wins.
// Optional macro REGFILE_BYPASS_EN: a read matching an enabled same-cycle
// write returns the write data instead of the stored value.
import regfile_pkg::*;

module multiport_register_file #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = DEFAULT_NUM_RD,
  parameter int NUM_WR = DEFAULT_NUM_WR
) (
  input  logic                         clk,
  input  logic                         reset,
  multiport_register_file_if.slave     bus
);

  localparam int DEPTH = 2**ADDR_W;

  if (!in_range(NUM_RD, MIN_RD_PORTS, MAX_RD_PORTS)) begin : g_bad_num_rd
    $error("multiport_register_file: NUM_RD out of range");
  end
  if (!in_range(NUM_WR, MIN_WR_PORTS, MAX_WR_PORTS)) begin : g_bad_num_wr
    $error("multiport_register_file: NUM_WR out of range");
  end
  if (DEPTH <= REG_V0) begin : g_bad_addr_w
    $error("multiport_register_file: ADDR_W too small to hold REG_V0");
  end

  logic [DATA_W-1:0]          regs_q [DEPTH];
  logic [DATA_W-1:0]          regs_d [DEPTH];
  logic [NUM_WR-1:0]          wr_fire;
  logic [DEPTH-1:0]           busy;
  logic [NUM_RD*DATA_W-1:0]   rd_data_c;
  logic [NUM_RD-1:0]          rd_busy_c;

  // A write port takes effect only when enabled, globally enabled and
  // aimed at a nonzero register.
  always_comb begin
    wr_fire = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wr_fire[w] = bus.wr_en[w] && bus.clk_enable &&
                   (bus.wr_addr[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO));
    end
  end

  // Ascending port order makes the highest-indexed port the last writer.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_fire[w]) begin
        regs_d[bus.wr_addr[w*ADDR_W +: ADDR_W]] = bus.wr_data[w*DATA_W +: DATA_W];
      end
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .en_i       (bus.clk_enable),
    .set_en_i   (bus.mark_en),
    .set_addr_i (bus.mark_addr),
    .clr_en_i   (bus.wr_en),
    .clr_addr_i (bus.wr_addr),
    .busy_o     (busy)
  );

  // Busy is always the stored flag; only data may be forwarded. Everything
  // is forced to 0 during reset so a forwarded write cannot leak out.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_data_c[r*DATA_W +: DATA_W] = regs_q[bus.rd_addr[r*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_fire[w] &&
            (bus.wr_addr[w*ADDR_W +: ADDR_W] == bus.rd_addr[r*ADDR_W +: ADDR_W])) begin
          rd_data_c[r*DATA_W +: DATA_W] = bus.wr_data[w*DATA_W +: DATA_W];
        end
      end
`else
`endif
      rd_busy_c[r] = busy[bus.rd_addr[r*ADDR_W +: ADDR_W]];
    end
    if (!reset) begin
      rd_data_c = '0;
      rd_busy_c = '0;
    end
  end

  assign bus.rd_data     = rd_data_c;
  assign bus.rd_busy     = rd_busy_c;
  assign bus.register_v0 = reset ? regs_q[REG_V0] : '0;

endmodule
